// File: rtl/cpu_timing_pkg.sv
// Shared beat/phase encodings and the next-beat rule for the hard-wired controller's timing generator.
package cpu_timing_pkg;

    localparam logic [2:0] W1 = 3'b001;
    localparam logic [2:0] W2 = 3'b010;
    localparam logic [2:0] W3 = 3'b100;

    localparam logic [2:0] T1     = 3'b001;
    localparam logic [2:0] T2     = 3'b010;
    localparam logic [2:0] T3     = 3'b100;
    localparam logic [2:0] T_IDLE = 3'b000;

    localparam logic [2:0] TG_RESET_W = 3'b001;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } tg_state_e;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    // SHORT only matters in W1 and LONG only in W2; W3 always closes the instruction.
    function automatic logic [2:0] next_beat(input logic [2:0] w,
                                             input logic       short_req,
                                             input logic       long_req);
        logic [2:0] nb;
        case (w)
            W1:      nb = short_req ? W1 : W2;
            W2:      nb = long_req  ? W3 : W1;
            W3:      nb = W1;
            default: nb = W1;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronises an asynchronous pushbutton through SYNC_STAGES flops and emits a one-cycle rising-edge pulse.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus the delayed copy used by the edge detector.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/timing_generator.sv
// Beat/phase sequencer producing one-hot W[3:1] and T[3:1] for the hard-wired controller.
// Optional single-instruction stepping is enabled by defining TG_SINGLE_STEP_EN.
module timing_generator
    import cpu_timing_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       QD,
    input  logic       SHORT,
    input  logic       LONG,
    input  logic       STOP,
`ifdef TG_SINGLE_STEP_EN
    input  logic       STEP_MODE,
`endif
    output logic [2:0] W,
    output logic [2:0] T,
    output logic       RUNNING,
    output logic       BEAT_END
);

    tg_state_e  state_q, state_d;
    logic [2:0] w_q, w_d;
    logic [2:0] t_q, t_d;
    logic       qd_rise_s;
    logic [2:0] beat_nx_s;
    logic       halt_req_s;

    btn_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_qd_sync (
        .clk_i (CLK),
        .rst_i (CLR),
        .btn_i (QD),
        .rise_o(qd_rise_s)
    );

    // State, phase and beat registers.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= ST_HALT;
            w_q     <= TG_RESET_W;
            t_q     <= T_IDLE;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            t_q     <= t_d;
        end
    end

    // Next-state logic: phase rotation, beat selection at T3, halt and start handling.
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        t_d       = t_q;
        beat_nx_s = next_beat(w_q, SHORT, LONG);
`ifdef TG_SINGLE_STEP_EN
        halt_req_s = STOP | (STEP_MODE & (beat_nx_s == W1));
`else
        halt_req_s = STOP;
`endif
        if (!is_onehot3(w_q)) begin
            state_d = ST_HALT;
            w_d     = TG_RESET_W;
            t_d     = T_IDLE;
        end else begin
            case (state_q)
                ST_HALT: begin
                    if (t_q != T_IDLE) begin
                        w_d = TG_RESET_W;
                        t_d = T_IDLE;
                    end else if (qd_rise_s) begin
                        state_d = ST_RUN;
                        t_d     = T1;
                    end else begin
                        t_d = T_IDLE;
                    end
                end
                ST_RUN: begin
                    case (t_q)
                        T1: t_d = T2;
                        T2: t_d = T3;
                        T3: begin
                            // The beat still advances on a halt so a restart resumes the sequence.
                            w_d = beat_nx_s;
                            if (halt_req_s) begin
                                state_d = ST_HALT;
                                t_d     = T_IDLE;
                            end else begin
                                t_d = T1;
                            end
                        end
                        default: begin
                            state_d = ST_HALT;
                            w_d     = TG_RESET_W;
                            t_d     = T_IDLE;
                        end
                    endcase
                end
                default: begin
                    state_d = ST_HALT;
                    w_d     = TG_RESET_W;
                    t_d     = T_IDLE;
                end
            endcase
        end
    end

    assign W        = w_q;
    assign T        = t_q;
    assign RUNNING  = (state_q == ST_RUN);
    assign BEAT_END = t_q[2] & (state_q == ST_RUN);

endmodule

// File: tb/tb_timing_generator.sv
// Self-checking bench for timing_generator: directed scenarios then random stimulus against a beat/phase model.
module tb_timing_generator;

    localparam int SYNC_STAGES = 2;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       QD;
    logic       SHORT;
    logic       LONG;
    logic       STOP;
`ifdef TG_SINGLE_STEP_EN
    logic       STEP_MODE;
`endif
    logic [2:0] W;
    logic [2:0] T;
    logic       RUNNING;
    logic       BEAT_END;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    timing_generator #(
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .QD       (QD),
        .SHORT    (SHORT),
        .LONG     (LONG),
        .STOP     (STOP),
`ifdef TG_SINGLE_STEP_EN
        .STEP_MODE(STEP_MODE),
`endif
        .W        (W),
        .T        (T),
        .RUNNING  (RUNNING),
        .BEAT_END (BEAT_END)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: beat number 1..3, phase number 0..3 (0 = halted), history of sampled QD levels.
    int m_run;
    int m_beat;
    int m_phase;
    bit qd_hist[$];

    task automatic model_reset();
        m_run   = 0;
        m_beat  = 1;
        m_phase = 0;
        qd_hist.delete();
        for (int i = 0; i < SYNC_STAGES + 2; i++) qd_hist.push_back(1'b0);
    endtask

    always @(posedge CLK or posedge CLR) begin : model
        int nb;
        bit start;
        bit step_en;
        if (CLR) begin
            model_reset();
        end else begin
            qd_hist.push_front(QD);
            void'(qd_hist.pop_back());
            // A press seen SYNC_STAGES edges ago, absent the edge before, starts the sequencer now.
            start = qd_hist[SYNC_STAGES] && !qd_hist[SYNC_STAGES + 1];
`ifdef TG_SINGLE_STEP_EN
            step_en = STEP_MODE;
`else
            step_en = 1'b0;
`endif
            if (m_run != 0) begin
                if (m_phase == 3) begin
                    case (m_beat)
                        1:       nb = SHORT ? 1 : 2;
                        2:       nb = LONG ? 3 : 1;
                        default: nb = 1;
                    endcase
                    m_beat = nb;
                    if (STOP || (step_en && nb == 1)) begin
                        m_run   = 0;
                        m_phase = 0;
                    end else begin
                        m_phase = 1;
                    end
                end else begin
                    m_phase = m_phase + 1;
                end
            end else if (start) begin
                m_run   = 1;
                m_phase = 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en && !CLR) begin
            check_val("W", {29'd0, W}, 32'd1 << (m_beat - 1));
            check_val("T", {29'd0, T}, (m_run != 0) ? (32'd1 << (m_phase - 1)) : 32'd0);
            check_val("RUNNING", {31'd0, RUNNING}, (m_run != 0) ? 32'd1 : 32'd0);
            check_val("BEAT_END", {31'd0, BEAT_END}, (m_run != 0 && m_phase == 3) ? 32'd1 : 32'd0);
        end
    end

    task automatic cyc(input logic qd, input logic sh, input logic lg, input logic st, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            QD    = qd;
            SHORT = sh;
            LONG  = lg;
            STOP  = st;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_W"}, {29'd0, W}, 32'd1);
        check_val({pfx, "_T"}, {29'd0, T}, 32'd0);
        check_val({pfx, "_RUNNING"}, {31'd0, RUNNING}, 32'd0);
        check_val({pfx, "_BEAT_END"}, {31'd0, BEAT_END}, 32'd0);
    endtask

    // Asynchronous clear between clock edges, checked before any further clock edge.
    task automatic clr_pulse();
        @(negedge CLK);
        #1 CLR = 1'b1;
        #1 check_reset_outputs("async_clr");
        #1 CLR = 1'b0;
    endtask

    initial begin
        CLR   = 1'b0;
        QD    = 1'b0;
        SHORT = 1'b0;
        LONG  = 1'b0;
        STOP  = 1'b0;
`ifdef TG_SINGLE_STEP_EN
        STEP_MODE = 1'b0;
`endif
        model_reset();
        #2 CLR = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge CLK);
        @(negedge CLK);
        CLR    = 1'b0;
        cmp_en = 1'b1;

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 14);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 10);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 6);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4);
        clr_pulse();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12);

`ifdef TG_SINGLE_STEP_EN
        STEP_MODE = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 14);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 14);
        STEP_MODE = 1'b0;
`endif

        for (int blk = 0; blk < 3; blk++) begin
            for (int i = 0; i < 1000; i++) begin
                @(negedge CLK);
                if ($urandom_range(5, 0) == 0) QD = ~QD;
                SHORT = 1'($urandom_range(1, 0));
                LONG  = 1'($urandom_range(1, 0));
                STOP  = ($urandom_range(15, 0) == 0);
`ifdef TG_SINGLE_STEP_EN
                if ($urandom_range(99, 0) == 0) STEP_MODE = ~STEP_MODE;
`endif
            end
            clr_pulse();
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
